aes_ctr_stream: RTL



---
 rtl/aes_pkg.sv | 15 +
 rtl/sync_fifo.sv | 49 ++++
 rtl/aes_ctr_stream.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared constants and types for the AES counter-mode stream wrapper.
// The core latency is derived from the round count of the pipelined AES core.
package aes_pkg;
   localparam int DATA_WIDTH   = 128;
   localparam int NONCE_WIDTH  = 96;
   localparam int CTR_WIDTH    = 32;
   localparam int NUM_ROUNDS   = 14;
   localparam int CORE_LATENCY = NUM_ROUNDS + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; DEPTH must be a power of two.
// Push when full and pop when empty are ignored.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign do_push = push && (count != (AW+1)'(DEPTH));
   assign do_pop  = pop && (count != '0);
   assign empty   = (count == '0);
   assign dout    = mem[rd_ptr];

   // storage carries no reset; only the pointers define what is valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/aes_ctr_stream.sv
// CTR-mode wrapper around a pipelined, non-stallable AES core: issues counter
// blocks, aligns plaintext with returning keystream, and buffers the result.
module aes_ctr_stream #(
   parameter int KEY_WIDTH   = 256,
   parameter int DATA_WIDTH  = aes_pkg::DATA_WIDTH,
   parameter int NONCE_WIDTH = aes_pkg::NONCE_WIDTH,
   parameter int CTR_WIDTH   = aes_pkg::CTR_WIDTH,
   parameter int DEPTH       = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic                   keyLen,
   input  logic [NONCE_WIDTH-1:0] nonce_in,
   input  logic [CTR_WIDTH-1:0]   ctr_init,
   input  logic                   pt_valid,
   output logic                   pt_ready,
   input  logic [DATA_WIDTH-1:0]  pt_data,
   input  logic                   pt_last,
   output logic                   ct_valid,
   input  logic                   ct_ready,
   output logic [DATA_WIDTH-1:0]  ct_data,
   output logic                   ct_last,
   output logic                   core_valid_in,
   output logic [DATA_WIDTH-1:0]  core_block,
   output logic [KEY_WIDTH-1:0]   core_key,
   output logic                   core_keyLen,
   input  logic                   core_valid_out,
   input  logic [DATA_WIDTH-1:0]  core_ct,
   output logic                   busy,
   output logic                   done,
   output logic                   exhausted,
   output logic                   err
);
   import aes_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < CORE_LATENCY + 2 || (DEPTH & (DEPTH - 1)) != 0 ||
       NONCE_WIDTH + CTR_WIDTH != DATA_WIDTH) begin : g_param_check
      $error("aes_ctr_stream: DEPTH must be a power of two >= core latency + 2 and nonce+ctr must fill a block");
   end

   state_t                 state;
   state_t                 state_next;
   logic [CW-1:0]          credits;
   logic [NONCE_WIDTH-1:0] nonce;
   logic [CTR_WIDTH-1:0]   ctr;
   logic                   accept;
   logic                   ct_pop;
   logic                   al_pop;
   logic                   al_empty;
   logic                   out_empty;
   logic [DATA_WIDTH:0]    al_dout;
   logic [DATA_WIDTH:0]    out_din;
   logic [DATA_WIDTH:0]    out_dout;

   assign pt_ready = (state == ST_RUN) && (credits != '0) && !exhausted;
   assign accept   = pt_valid && pt_ready;
   assign ct_valid = !out_empty;
   assign ct_pop   = ct_valid && ct_ready;
   assign al_pop   = core_valid_out && !al_empty;
   assign out_din  = {core_ct ^ al_dout[DATA_WIDTH:1], al_dout[0]};
   assign ct_data  = ct_valid ? out_dout[DATA_WIDTH:1] : '0;
   assign ct_last  = ct_valid & out_dout[0];
   assign busy     = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE:  if (start) state_next = ST_RUN;
         ST_RUN:   if (accept && pt_last) state_next = ST_DRAIN;
         ST_DRAIN: if (credits == CW'(DEPTH)) state_next = ST_IDLE;
         default:  state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits       <= CW'(DEPTH);
         nonce         <= '0;
         ctr           <= '0;
         core_key      <= '0;
         core_keyLen   <= 1'b0;
         core_valid_in <= 1'b0;
         core_block    <= '0;
         exhausted     <= 1'b0;
         err           <= 1'b0;
         done          <= 1'b0;
      end else begin
         done          <= (state == ST_DRAIN) && (state_next == ST_IDLE);
         core_valid_in <= accept;
         if (state == ST_IDLE && start) begin
            core_key    <= key_in;
            core_keyLen <= keyLen;
            nonce       <= nonce_in;
            ctr         <= ctr_init;
            exhausted   <= 1'b0;
            err         <= 1'b0;
         end
         if (accept) begin
            core_block <= {nonce, ctr};
            ctr        <= ctr + CTR_WIDTH'(1);
            if (&ctr) exhausted <= 1'b1;
         end
         // keystream with no waiting plaintext is dropped and only flagged
         if (core_valid_out && al_empty) err <= 1'b1;
         case ({accept, ct_pop})
            2'b10:   credits <= credits - 1'b1;
            2'b01:   credits <= credits + 1'b1;
            default: credits <= credits;
         endcase
      end
   end

   sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH)) u_align_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   ({pt_data, pt_last}),
      .pop   (al_pop),
      .dout  (al_dout),
      .empty (al_empty)
   );

   sync_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(DEPTH)) u_out_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (al_pop),
      .din   (out_din),
      .pop   (ct_pop),
      .dout  (out_dout),
      .empty (out_empty)
   );
endmodule
